// File: rtl/lat_mem_if.sv
// Request/response bundle for lat_mem: the master issues word accesses and the slave answers
// with a one-cycle ready pulse carrying rdata/err.
interface lat_mem_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic                  req;
  logic                  wen;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   wstrb;
  logic [ADDR_W-1:0]     offset;
  logic                  busy;
  logic                  ready;
  logic [DATA_W-1:0]     rdata;
  logic                  err;

  modport master (
    output req, wen, addr, wdata, wstrb, offset,
    input  busy, ready, rdata, err
  );

  modport slave (
    input  req, wen, addr, wdata, wstrb, offset,
    output busy, ready, rdata, err
  );
endinterface

// File: rtl/lat_mem.sv
// Offset-mapped word memory with programmable response latency and byte strobes.
// Define LAT_MEM_ALIGN_CHECK_EN to flag accesses with addr[1:0] != 0 as errors.
module lat_mem #(
  parameter int WORD_DEPTH = 36,
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int LATENCY    = 1
) (
  input  logic      clk,
  input  logic      rst,
  lat_mem_if.slave  mem_if
);

  localparam int         NB       = DATA_W / 8;
  localparam int         IDX_W    = (WORD_DEPTH > 1) ? $clog2(WORD_DEPTH) : 1;
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   pend_rdata_q, pend_rdata_d;
  logic                pend_err_q, pend_err_d;

  logic [DATA_W-1:0]   mem      [WORD_DEPTH];
  logic [ADDR_W-1:0]   mem_addr [WORD_DEPTH];

  logic [ADDR_W-1:0]   rel_addr;
  logic [ADDR_W-1:0]   idx;
  logic [IDX_W-1:0]    word_idx;
  logic                hit;
  logic                acc_ok;
  logic                accept;
  logic [DATA_W-1:0]   acc_rdata;

  for (genvar i = 0; i < WORD_DEPTH; i++) begin : g_mem_addr
    assign mem_addr[i] = mem_if.offset + ADDR_W'(4 * i);
  end

  assign rel_addr = mem_if.addr - mem_if.offset;
  assign idx      = rel_addr >> 2;
  assign word_idx = idx[IDX_W-1:0];
  assign hit      = (mem_if.addr >= mem_if.offset) && (idx < ADDR_W'(WORD_DEPTH));

`ifdef LAT_MEM_ALIGN_CHECK_EN
  assign acc_ok = hit && (mem_if.addr[1:0] == 2'b00);
`else
  assign acc_ok = hit;
`endif

  assign accept = mem_if.req && !rst && (state_q != WAIT);

  // Write responses and rejected accesses carry rdata=0.
  assign acc_rdata = (acc_ok && !mem_if.wen) ? mem[word_idx] : '0;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    pend_rdata_d = pend_rdata_q;
    pend_err_d   = pend_err_q;

    case (state_q)
      IDLE, RESP: begin
        if (accept) begin
          cnt_d = CNT_LOAD;
          if (LATENCY == 1) begin
            state_d = RESP;
            rdata_d = acc_rdata;
            err_d   = !acc_ok;
          end else begin
            state_d      = WAIT;
            pend_rdata_d = acc_rdata;
            pend_err_d   = !acc_ok;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd1) begin
          state_d = RESP;
          rdata_d = pend_rdata_q;
          err_d   = pend_err_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      pend_rdata_q <= '0;
      pend_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      pend_rdata_q <= pend_rdata_d;
      pend_err_q   <= pend_err_d;
    end
  end

  // Storage is deliberately outside reset so preloaded contents survive it.
  always_ff @(posedge clk) begin
    if (accept && mem_if.wen && acc_ok) begin
      for (int b = 0; b < NB; b++) begin
        if (mem_if.wstrb[b]) begin
          mem[word_idx][8*b +: 8] <= mem_if.wdata[8*b +: 8];
        end
      end
    end
  end

  assign mem_if.busy  = (state_q == WAIT);
  assign mem_if.ready = (state_q == RESP);
  assign mem_if.rdata = rdata_q;
  assign mem_if.err   = err_q;

endmodule

// File: tb/tb_lat_mem.sv
// Bench for lat_mem: three instances (LATENCY 1, 3, 5) checked every cycle against a
// transaction-level model, plus directed scenarios with literal expectations.
module tb_lat_mem;

  localparam int N      = 3;
  localparam int DEPTH  = 36;
  localparam logic [31:0] OFFSET = 32'h0001_0000;

  logic        clk;
  logic        rstI   [N];
  logic        reqI   [N];
  logic        wenI   [N];
  logic [31:0] addrI  [N];
  logic [31:0] wdataI [N];
  logic [3:0]  wstrbI [N];
  logic        busyO  [N];
  logic        readyO [N];
  logic [31:0] rdataO [N];
  logic        errO   [N];

  for (genvar g = 0; g < N; g++) begin : gInst
    lat_mem_if #(.DATA_W(32), .ADDR_W(32)) bus ();
    assign bus.req    = reqI[g];
    assign bus.wen    = wenI[g];
    assign bus.addr   = addrI[g];
    assign bus.wdata  = wdataI[g];
    assign bus.wstrb  = wstrbI[g];
    assign bus.offset = OFFSET;
    assign busyO[g]   = bus.busy;
    assign readyO[g]  = bus.ready;
    assign rdataO[g]  = bus.rdata;
    assign errO[g]    = bus.err;

    lat_mem #(
      .WORD_DEPTH(DEPTH),
      .DATA_W(32),
      .ADDR_W(32),
      .LATENCY(2 * g + 1)
    ) dut (
      .clk(clk),
      .rst(rstI[g]),
      .mem_if(bus.slave)
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checkCount = 0;
  int passCount  = 0;
  bit checkEn    = 1'b0;
  int cycle      = 0;

  // Transaction-level model: one outstanding response per instance, due on a known cycle.
  logic [31:0] modelMem  [N][DEPTH];
  bit          pendValid [N] = '{default: 1'b0};
  int          pendDue   [N];
  logic [31:0] pendRdata [N];
  logic        pendErr   [N];
  logic [31:0] lastRdata [N] = '{default: 32'h0};
  logic        lastErr   [N] = '{default: 1'b0};

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, actual, expected, $time);
  endtask

  function automatic logic [31:0] preloadWord(input int i);
    if (i == 0) return 32'h1234_5678;
    if (i == 1) return 32'hDEAD_BEEF;
    if (i == 2) return 32'hAAAA_AAAA;
    return 32'h0F00_0000 + 32'(i);
  endfunction

  always @(posedge clk) begin
    int prev;
    prev = cycle;
    cycle = cycle + 1;
    for (int k = 0; k < N; k++) begin
      if (rstI[k]) begin
        pendValid[k] = 1'b0;
        lastRdata[k] = 32'h0;
        lastErr[k]   = 1'b0;
      end else if (reqI[k] && !(pendValid[k] && pendDue[k] > prev)) begin
        logic inRange, ok;
        int word;
        inRange = (addrI[k] >= OFFSET) && ((addrI[k] - OFFSET) / 4 < DEPTH);
        word    = inRange ? int'((addrI[k] - OFFSET) / 4) : 0;
`ifdef LAT_MEM_ALIGN_CHECK_EN
        ok = inRange && (addrI[k] % 4 == 0);
`else
        ok = inRange;
`endif
        pendRdata[k] = 32'h0;
        if (wenI[k]) begin
          if (ok)
            for (int b = 0; b < 4; b++)
              if (wstrbI[k][b]) modelMem[k][word][8*b +: 8] = wdataI[k][8*b +: 8];
        end else if (ok) begin
          pendRdata[k] = modelMem[k][word];
        end
        pendErr[k]   = !ok;
        pendDue[k]   = cycle + (2 * k + 1) - 1;
        pendValid[k] = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < N; k++) begin
      logic expReady, expBusy;
      expReady = pendValid[k] && (pendDue[k] == cycle);
      expBusy  = pendValid[k] && (pendDue[k] > cycle);
      if (expReady) begin
        lastRdata[k] = pendRdata[k];
        lastErr[k]   = pendErr[k];
        pendValid[k] = 1'b0;
      end
      if (checkEn) begin
        checkOutput($sformatf("inst%0d ready", k), 32'(readyO[k]), 32'(expReady));
        checkOutput($sformatf("inst%0d busy", k), 32'(busyO[k]), 32'(expBusy));
        checkOutput($sformatf("inst%0d rdata", k), rdataO[k], lastRdata[k]);
        checkOutput($sformatf("inst%0d err", k), 32'(errO[k]), 32'(lastErr[k]));
      end
    end
  end

  task automatic applyStimulus(input int k, input logic w, input logic [31:0] a,
                               input logic [31:0] d, input logic [3:0] s, output logic rdyAtIssue);
    bit freed = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (!busyO[k]) begin
        freed = 1'b1;
        break;
      end
    end
    if (!freed) checkOutput($sformatf("inst%0d issue wait", k), 32'(busyO[k]), 32'h0);
    rdyAtIssue = readyO[k];
    reqI[k]   = 1'b1;
    wenI[k]   = w;
    addrI[k]  = a;
    wdataI[k] = d;
    wstrbI[k] = s;
    @(posedge clk);
    #1;
  endtask

  task automatic waitResponse(input int k, output logic [31:0] rd, output logic er,
                              output int lat, output int busyCnt);
    bit seen = 1'b0;
    reqI[k] = 1'b0;
    lat = 0;
    busyCnt = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      lat++;
      if (readyO[k]) begin
        seen = 1'b1;
        break;
      end
      if (busyO[k]) busyCnt++;
    end
    if (!seen) checkOutput($sformatf("inst%0d response wait", k), 32'(readyO[k]), 32'h1);
    rd = rdataO[k];
    er = errO[k];
  endtask

  task automatic access(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] rd, output logic er, output int lat);
    logic rdy;
    int bc;
    applyStimulus(k, w, a, d, s, rdy);
    waitResponse(k, rd, er, lat, bc);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    logic        er, rdy;
    int          lat, bc, readyCnt;

    for (int k = 0; k < N; k++) begin
      rstI[k] = 1'b1; reqI[k] = 1'b0; wenI[k] = 1'b0;
      addrI[k] = '0; wdataI[k] = '0; wstrbI[k] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < N; k++) rstI[k] = 1'b0;
    checkEn = 1'b1;

    for (int k = 0; k < N; k++)
      for (int i = 0; i < DEPTH; i++)
        access(k, 1'b1, OFFSET + 32'(4 * i), preloadWord(i), 4'hF, rd, er, lat);

    // Reset held two cycles with a full-strobe write to word 0 pending on every instance.
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      rstI[k] = 1'b1; reqI[k] = 1'b1; wenI[k] = 1'b1;
      addrI[k] = OFFSET; wdataI[k] = 32'hFFFF_FFFF; wstrbI[k] = 4'hF;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      checkOutput("reset ready", 32'(readyO[k]), 32'h0);
      checkOutput("reset busy", 32'(busyO[k]), 32'h0);
      checkOutput("reset rdata", rdataO[k], 32'h0);
      checkOutput("reset err", 32'(errO[k]), 32'h0);
      rstI[k] = 1'b0; reqI[k] = 1'b0;
    end
    for (int k = 0; k < N; k++) begin
      access(k, 1'b0, OFFSET, 32'h0, 4'h0, rd, er, lat);
      checkOutput("mem0 intact after reset", rd, 32'h1234_5678);
    end

    applyStimulus(1, 1'b0, OFFSET + 32'h4, 32'h0, 4'h0, rdy);
    waitResponse(1, rd, er, lat, bc);
    checkOutput("lat3 latency", 32'(lat), 32'd3);
    checkOutput("lat3 busy cycles", 32'(bc), 32'd2);
    checkOutput("lat3 rdata", rd, 32'hDEAD_BEEF);
    checkOutput("lat3 err", 32'(er), 32'h0);

    access(1, 1'b1, OFFSET + 32'h8, 32'h1122_3344, 4'b0101, rd, er, lat);
    access(1, 1'b0, OFFSET + 32'h8, 32'h0, 4'h0, rd, er, lat);
    checkOutput("strobe merge", rd, 32'hAA22_AA44);

    applyStimulus(0, 1'b1, OFFSET, 32'h5, 4'hF, rdy);
    applyStimulus(0, 1'b0, OFFSET, 32'h0, 4'h0, rdy);
    checkOutput("b2b first ready", 32'(rdy), 32'h1);
    waitResponse(0, rd, er, lat, bc);
    checkOutput("b2b read latency", 32'(lat), 32'd1);
    checkOutput("b2b read data", rd, 32'h0000_0005);

    access(0, 1'b1, OFFSET + 32'hC, 32'hFFFF_FFFF, 4'h0, rd, er, lat);
    checkOutput("zero strobe err", 32'(er), 32'h0);
    access(0, 1'b0, OFFSET + 32'hC, 32'h0, 4'h0, rd, er, lat);
    checkOutput("zero strobe unchanged", rd, 32'h0F00_0003);

    access(1, 1'b0, OFFSET + 32'(4 * (DEPTH - 1)), 32'h0, 4'h0, rd, er, lat);
    checkOutput("last word rdata", rd, 32'h0F00_0023);
    checkOutput("last word err", 32'(er), 32'h0);
    access(1, 1'b0, OFFSET + 32'(4 * DEPTH), 32'h0, 4'h0, rd, er, lat);
    checkOutput("oor read err", 32'(er), 32'h1);
    checkOutput("oor read rdata", rd, 32'h0);
    access(1, 1'b1, OFFSET - 32'h4, 32'hCAFE_F00D, 4'hF, rd, er, lat);
    checkOutput("oor write err", 32'(er), 32'h1);
    access(1, 1'b0, OFFSET, 32'h0, 4'h0, rd, er, lat);
    checkOutput("oor write no change", rd, 32'h1234_5678);

    // Reset two edges after acceptance on the LATENCY=5 instance must swallow the response.
    applyStimulus(2, 1'b0, OFFSET + 32'h4, 32'h0, 4'h0, rdy);
    reqI[2] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstI[2] = 1'b1;
    @(negedge clk);
    rstI[2] = 1'b0;
    readyCnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (readyO[2]) readyCnt++;
    end
    checkOutput("aborted ready pulses", 32'(readyCnt), 32'h0);

    access(2, 1'b0, OFFSET + 32'h2, 32'h0, 4'h0, rd, er, lat);
`ifdef LAT_MEM_ALIGN_CHECK_EN
    checkOutput("misaligned err", 32'(er), 32'h1);
    checkOutput("misaligned rdata", rd, 32'h0);
`else
    checkOutput("misaligned err", 32'(er), 32'h0);
    checkOutput("misaligned rdata", rd, 32'h1234_5678);
`endif

    repeat (3) @(negedge clk);
    checkEn = 1'b0;
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
